// File: rtl/sram_resp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_resp_pkg : shared constants for the SRAM responder slice    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sram_resp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam logic [31:0] DEFAULT_BASE = 32'h1c00_0000;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;
    localparam int CNT_W = 3;

    // Word offset from the window base; callers truncate to the array depth.
    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_resp_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_resp_mem : single-port synchronous 32-bit RAM, byte lanes   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sram_resp_mem #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            wstrb,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [3:0][7:0] mem_q [2**DEPTH_LOG2];
    logic [31:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_q[addr][i] <= wdata[8*i +: 8];
                end
            end
        end else begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_responder : inst/data SRAM-style slave, fixed-latency reply |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE       = DEFAULT_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam logic [CNT_W-1:0] CNT_INIT    = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
    localparam logic [1:0]       ACCEPT_NEXT = (LATENCY == 1) ? ST_RESP : ST_WAIT;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic                  wr_q, wr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           inst_rdata_q, inst_rdata_d;
    logic [31:0]           data_rdata_q, data_rdata_d;

    logic                  data_accept, inst_accept, in_resp, mem_we;
    logic [DEPTH_LOG2-1:0] accept_idx, mem_addr;
    logic [31:0]           mem_rdata;

    always_comb begin
        data_accept = (state_q == ST_IDLE) && data_req && !reset;
        inst_accept = (state_q == ST_IDLE) && inst_req && !data_req && !reset;
        accept_idx  = DEPTH_LOG2'(word_offset(data_req ? data_addr : inst_addr, BASE));
        in_resp     = (state_q == ST_RESP) && !reset;
        mem_we      = in_resp && wr_q;
        // The read issued in the cycle before RESP lands in mem_rdata during RESP.
        mem_addr    = (state_q == ST_IDLE) ? accept_idx : idx_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        wstrb_d = wstrb_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (data_accept || inst_accept) begin
                    port_d  = data_accept ? PORT_DATA : PORT_INST;
                    wr_d    = data_accept && data_wr;
                    wstrb_d = data_wstrb;
                    idx_d   = accept_idx;
                    wdata_d = data_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ACCEPT_NEXT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Each port's read data holds until that port's next load response.
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (reset) begin
            inst_rdata_d = '0;
            data_rdata_d = '0;
        end else if (in_resp && (port_q == PORT_INST)) begin
            inst_rdata_d = mem_rdata;
        end else if (in_resp && (port_q == PORT_DATA) && !wr_q) begin
            data_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            port_q       <= PORT_INST;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    sram_resp_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .wstrb (wstrb_q),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign data_addr_ok = data_accept;
    assign inst_addr_ok = inst_accept;
    assign inst_data_ok = in_resp && (port_q == PORT_INST);
    assign data_data_ok = in_resp && (port_q == PORT_DATA);
    assign inst_rdata   = inst_rdata_d;
    assign data_rdata   = data_rdata_d;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sram_responder : randomized bench against a word-array model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sram_responder;

    localparam int          NI     = 3;
    localparam logic [31:0] C_BASE = 32'h1c00_0000;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int dl_of(input int k);
        case (k)
            0:       return 4;
            1:       return 12;
            default: return 6;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset_s        [NI];
    logic        inst_req_s     [NI];
    logic [31:0] inst_addr_s    [NI];
    logic        inst_addr_ok_s [NI];
    logic        inst_data_ok_s [NI];
    logic [31:0] inst_rdata_s   [NI];
    logic        data_req_s     [NI];
    logic        data_wr_s      [NI];
    logic [3:0]  data_wstrb_s   [NI];
    logic [31:0] data_addr_s    [NI];
    logic [31:0] data_wdata_s   [NI];
    logic        data_addr_ok_s [NI];
    logic        data_data_ok_s [NI];
    logic [31:0] data_rdata_s   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_responder #(
            .DEPTH_LOG2 (dl_of(g)),
            .LATENCY    (lat_of(g)),
            .BASE       (C_BASE)
        ) u_dut (
            .clk          (clk),
            .reset        (reset_s[g]),
            .inst_req     (inst_req_s[g]),
            .inst_addr    (inst_addr_s[g]),
            .inst_addr_ok (inst_addr_ok_s[g]),
            .inst_data_ok (inst_data_ok_s[g]),
            .inst_rdata   (inst_rdata_s[g]),
            .data_req     (data_req_s[g]),
            .data_wr      (data_wr_s[g]),
            .data_wstrb   (data_wstrb_s[g]),
            .data_addr    (data_addr_s[g]),
            .data_wdata   (data_wdata_s[g]),
            .data_addr_ok (data_addr_ok_s[g]),
            .data_data_ok (data_data_ok_s[g]),
            .data_rdata   (data_rdata_s[g])
        );
    end

    // Reference: a plain word array per instance plus last value seen on each port.
    logic [31:0] mdl       [NI][4096];
    logic [31:0] last_inst [NI];
    logic [31:0] last_data [NI];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input int k, input logic [31:0] addr);
        return int'(((addr - C_BASE) >> 2) & ((32'd1 << dl_of(k)) - 32'd1));
    endfunction

    // Called just after the accepting edge; follows the transaction to its response.
    task automatic watch(input int k, input bit is_data, input bit wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          idx;
        logic [31:0] exp;
        idx = word_of(k, addr);
        for (int c = 1; c <= lat_of(k); c++) begin
            @(negedge clk);
            check("addr_ok_busy", 32'({inst_addr_ok_s[k], data_addr_ok_s[k]}), 32'd0);
            check(is_data ? "data_ok_timing" : "inst_ok_timing",
                  is_data ? data_data_ok_s[k] : inst_data_ok_s[k], c == lat_of(k));
            check("other_ok_quiet", is_data ? inst_data_ok_s[k] : data_data_ok_s[k], 1'b0);
            if (c == lat_of(k)) begin
                if (is_data && wr) begin
                    check("store_keeps_data_rdata", data_rdata_s[k], last_data[k]);
                    check("store_keeps_inst_rdata", inst_rdata_s[k], last_inst[k]);
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end else if (is_data) begin
                    exp = mdl[k][idx];
                    check("load_data_rdata", data_rdata_s[k], exp);
                    check("load_keeps_inst_rdata", inst_rdata_s[k], last_inst[k]);
                    last_data[k] = exp;
                end else begin
                    exp = mdl[k][idx];
                    check("fetch_inst_rdata", inst_rdata_s[k], exp);
                    check("fetch_keeps_data_rdata", data_rdata_s[k], last_data[k]);
                    last_inst[k] = exp;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Single transaction from IDLE: must be accepted in the first cycle.
    task automatic txn(input int k, input bit is_data, input bit wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bit got;
        int waited;
        got    = 1'b0;
        waited = 0;
        if (is_data) begin
            data_req_s[k]   = 1'b1;
            data_wr_s[k]    = wr;
            data_wstrb_s[k] = strb;
            data_addr_s[k]  = addr;
            data_wdata_s[k] = wdata;
        end else begin
            inst_req_s[k]  = 1'b1;
            inst_addr_s[k] = addr;
        end
        while (!got && waited < 8) begin
            @(negedge clk);
            got = is_data ? data_addr_ok_s[k] : inst_addr_ok_s[k];
            if (!got) waited++;
            @(posedge clk);
            #1;
        end
        data_req_s[k] = 1'b0;
        inst_req_s[k] = 1'b0;
        check("accept_first_cycle", 32'(waited), 32'd0);
        if (got) watch(k, is_data, wr, strb, addr, wdata);
    endtask

    // Both ports request together; optionally the data port re-requests after its response.
    task automatic arb(input int k, input logic [31:0] a_d, input logic [31:0] a_i, input bit again);
        data_req_s[k]  = 1'b1;
        data_wr_s[k]   = 1'b0;
        data_addr_s[k] = a_d;
        inst_req_s[k]  = 1'b1;
        inst_addr_s[k] = a_i;
        @(negedge clk);
        check("arb_data_granted", data_addr_ok_s[k], 1'b1);
        check("arb_inst_blocked", inst_addr_ok_s[k], 1'b0);
        @(posedge clk);
        #1;
        if (!again) data_req_s[k] = 1'b0;
        watch(k, 1'b1, 1'b0, 4'h0, a_d, 32'd0);
        if (again) begin
            @(negedge clk);
            check("arb_data_again", data_addr_ok_s[k], 1'b1);
            check("arb_inst_still_blocked", inst_addr_ok_s[k], 1'b0);
            @(posedge clk);
            #1;
            data_req_s[k] = 1'b0;
            watch(k, 1'b1, 1'b0, 4'h0, a_d, 32'd0);
        end
        @(negedge clk);
        check("arb_inst_granted", inst_addr_ok_s[k], 1'b1);
        @(posedge clk);
        #1;
        inst_req_s[k] = 1'b0;
        watch(k, 1'b0, 1'b0, 4'h0, a_i, 32'd0);
    endtask

    task automatic reset_mid(input int k, input logic [31:0] a);
        data_req_s[k]   = 1'b1;
        data_wr_s[k]    = 1'b1;
        data_wstrb_s[k] = 4'hF;
        data_addr_s[k]  = a;
        data_wdata_s[k] = ~mdl[k][word_of(k, a)];
        @(negedge clk);
        check("rst_store_accept", data_addr_ok_s[k], 1'b1);
        @(posedge clk);
        #1;
        data_req_s[k] = 1'b0;
        @(negedge clk);
        check("rst_wait_no_ok", data_data_ok_s[k], 1'b0);
        @(posedge clk);
        #1;
        reset_s[k]    = 1'b1;
        data_req_s[k] = 1'b1;
        inst_req_s[k] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_addr_ok_zero", 32'({inst_addr_ok_s[k], data_addr_ok_s[k]}), 32'd0);
            check("rst_data_ok_zero", 32'({inst_data_ok_s[k], data_data_ok_s[k]}), 32'd0);
            check("rst_inst_rdata_zero", inst_rdata_s[k], 32'd0);
            check("rst_data_rdata_zero", data_rdata_s[k], 32'd0);
            @(posedge clk);
            #1;
        end
        reset_s[k]    = 1'b0;
        data_req_s[k] = 1'b0;
        inst_req_s[k] = 1'b0;
        last_inst[k]  = 32'd0;
        last_data[k]  = 32'd0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_late_ok", 32'({inst_data_ok_s[k], data_data_ok_s[k]}), 32'd0);
            @(posedge clk);
            #1;
        end
        txn(k, 1'b1, 1'b0, 4'h0, a, 32'd0);
    endtask

    initial begin
        bit          is_data, wr;
        int          w, al;
        logic [31:0] addr;

        for (int k = 0; k < NI; k++) begin
            reset_s[k]      = 1'b1;
            inst_req_s[k]   = 1'b1;
            inst_addr_s[k]  = C_BASE;
            data_req_s[k]   = 1'b1;
            data_wr_s[k]    = 1'b0;
            data_wstrb_s[k] = 4'h0;
            data_addr_s[k]  = C_BASE;
            data_wdata_s[k] = 32'd0;
            last_inst[k]    = 32'd0;
            last_data[k]    = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_addr_ok", 32'({inst_addr_ok_s[k], data_addr_ok_s[k]}), 32'd0);
            check("reset_data_ok", 32'({inst_data_ok_s[k], data_data_ok_s[k]}), 32'd0);
            check("reset_inst_rdata", inst_rdata_s[k], 32'd0);
            check("reset_data_rdata", data_rdata_s[k], 32'd0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            reset_s[k]    = 1'b0;
            inst_req_s[k] = 1'b0;
            data_req_s[k] = 1'b0;
        end

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 32; i++) begin
                txn(k, 1'b1, 1'b1, 4'hF, C_BASE + 32'(4 * i), $urandom);
            end
        end

        txn(0, 1'b1, 1'b1, 4'hF, 32'h1c00_0010, 32'hDEAD_BEEF);
        txn(0, 1'b1, 1'b0, 4'h0, 32'h1c00_0010, 32'd0);
        check("store_load_deadbeef", data_rdata_s[0], 32'hDEAD_BEEF);
        txn(0, 1'b1, 1'b1, 4'hF, 32'h1c00_0020, 32'h1122_3344);
        txn(0, 1'b1, 1'b1, 4'b0101, 32'h1c00_0020, 32'hAABB_CCDD);
        txn(0, 1'b1, 1'b0, 4'h0, 32'h1c00_0020, 32'd0);
        check("partial_store", data_rdata_s[0], 32'h11BB_33DD);
        txn(0, 1'b1, 1'b1, 4'hF, 32'h1c00_0040, 32'h1234_5678);
        txn(0, 1'b1, 1'b0, 4'h0, 32'h1c00_0000, 32'd0);
        check("wrap_alias", data_rdata_s[0], 32'h1234_5678);
        txn(0, 1'b1, 1'b1, 4'h0, 32'h1c00_0024, 32'hFFFF_FFFF);
        txn(0, 1'b0, 1'b0, 4'h0, 32'h1c00_0024, 32'd0);

        arb(0, C_BASE + 32'h8, C_BASE + 32'hC, 1'b0);
        arb(1, C_BASE + 32'h10, C_BASE + 32'h14, 1'b1);
        arb(2, C_BASE + 32'h18, C_BASE + 32'h1C, 1'b0);

        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 60; n++) begin
                is_data = 1'($urandom_range(1, 0));
                wr      = is_data && ($urandom_range(1, 0) == 1);
                w       = int'($urandom_range(31, 0));
                al      = int'($urandom_range(4, 0)) - 2;
                addr    = C_BASE + 32'((w + al * (1 << dl_of(k))) * 4) + 32'($urandom_range(3, 0));
                txn(k, is_data, wr, 4'($urandom_range(15, 0)), addr, $urandom);
            end
        end

        reset_mid(2, C_BASE + 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, log2 of the number of 32-bit words in the backing array.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request accept to data_ok; legal range 1..7.
REQ-003 SHALL have parameter BASE, default 32'h1c00_0000, byte address that maps to word 0.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 inst_req  in  1  instruction-fetch read request; held until accepted.
REQ-007 inst_addr  in  32  fetch byte address.
REQ-008 inst_addr_ok  out  1  inst request accepted this cycle.
REQ-009 inst_data_ok  out  1  inst read data valid this cycle.
REQ-010 inst_rdata  out  32  fetched word.
REQ-011 data_req  in  1  load/store request; held until accepted.
REQ-012 data_wr  in  1  1 = store, 0 = load.
REQ-013 data_wstrb  in  4  byte enables for stores; bit i enables byte lane i.
REQ-014 data_addr  in  32  load/store byte address.
REQ-015 data_wdata  in  32  store data.
REQ-016 data_addr_ok  out  1  data request accepted this cycle.
REQ-017 data_data_ok  out  1  load data valid, or store completed, this cycle.
REQ-018 data_rdata  out  32  loaded word.

Function
REQ-019 Word index SHALL be ((addr - BASE) >> 2) mod 2^DEPTH_LOG2; addr[1:0] ignored; out-of-window addresses wrap, no error.
REQ-020 FSM SHALL have states IDLE, WAIT, RESP; one transaction outstanding at a time.
REQ-021 In IDLE, addr_ok SHALL be combinational: data_addr_ok = data_req; inst_addr_ok = inst_req & ~data_req.
REQ-022 Simultaneous inst_req and data_req SHALL grant data; inst waits with inst_addr_ok = 0 and is accepted once IDLE recurs with no data_req.
REQ-023 On accept, the FSM SHALL latch port id, wr, wstrb, word index, wdata; go to RESP if LATENCY = 1, else to WAIT with counter = LATENCY-2.
REQ-024 WAIT SHALL decrement the counter each cycle and go to RESP when the counter is 0.
REQ-025 Accept in cycle T SHALL produce a one-cycle data_ok on the granted port in cycle T+LATENCY; RESP always returns to IDLE.
REQ-026 No addr_ok SHALL assert in WAIT or RESP; peak throughput is one transaction per LATENCY+1 cycles.
REQ-027 Stores SHALL write the array on the rising edge ending the RESP cycle, enabled lanes only; wstrb = 4'b0000 still completes the handshake with no array change.
REQ-028 Loads SHALL register the array word into the port's rdata at RESP entry, so rdata is valid with data_ok.
REQ-029 Each rdata SHALL hold its value until that port's next load response; stores SHALL leave data_rdata unchanged.
REQ-030 A load SHALL return data that includes every store completed earlier.
REQ-031 data_ok on both ports in the same cycle SHALL never occur.

Reset
REQ-032 While reset = 1: state = IDLE; all addr_ok = 0, all data_ok = 0; inst_rdata = data_rdata = 0.
REQ-033 Reset mid-transaction SHALL drop the transaction with no data_ok and no array write.
REQ-034 Array contents SHALL NOT be cleared by reset.

Structure
REQ-035 Package sram_resp_pkg SHALL hold the state enumeration, port-id encoding, default BASE, and LATENCY min/max constants.
REQ-036 The array SHALL be a sub-module sram_resp_mem: one port, synchronous, 32-bit words, 4-lane byte write enable, 2^DEPTH_LOG2 words.
REQ-037 The FSM, arbitration, and latency counter SHALL reside in sram_responder.

Verification
REQ-038 Store then load, LATENCY=1: data store addr 1c00_0010, wdata DEADBEEF, wstrb F; then load same addr -> data_data_ok 1 cycle after each accept; data_rdata = DEADBEEF.
REQ-039 Partial store: preload 11223344 at 1c00_0020; store wdata AABBCCDD, wstrb 0101 -> subsequent load returns 11BB33DD.
REQ-040 Arbitration: inst_req and data_req both asserted at T in IDLE -> data_addr_ok at T, inst_addr_ok 0 at T; inst accepted at T+LATENCY+1.
REQ-041 LATENCY=4: load accepted at T -> data_data_ok high only at T+4; addr_ok low on both ports T+1..T+4.
REQ-042 Wrap, DEPTH_LOG2=4: store 12345678 to 1c00_0040, then load 1c00_0000 -> 12345678.
REQ-043 Reset in WAIT (LATENCY=3, store pending) -> no data_ok, array unchanged, outputs 0, next request accepted normally after reset.
